// File: rtl/vc_test_delay_sink.sv
// vc_test_delay_sink: test-harness sink that applies pseudo-random
// back-pressure to a val/rdy stream and checks every accepted message, in
// order, against an expected-message table loaded before the run.
module vc_test_delay_sink #(
  parameter int          p_msg_nbits = 32,
  parameter int          p_num_msgs  = 64,
  parameter int          p_max_delay = 7,
  parameter logic [15:0] p_lfsr_seed = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cfg_wen,
  input  logic [$clog2(p_num_msgs)-1:0]   cfg_waddr,
  input  logic [p_msg_nbits-1:0]          cfg_wdata,
  input  logic [$clog2(p_num_msgs):0]     cfg_num_msgs,
  input  logic                            start,
  input  logic                            in_val,
  output logic                            in_rdy,
  input  logic [p_msg_nbits-1:0]          in_msg,
  output logic                            done,
  output logic [15:0]                     num_errors,
  output logic                            err_pulse,
  output logic [$clog2(p_num_msgs)-1:0]   err_index
);

  localparam int AW = $clog2(p_num_msgs);
  localparam int NW = AW + 1;
  localparam int DW = (p_max_delay > 0) ? $clog2(p_max_delay + 1) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_ACCEPT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [NW-1:0]          n_latched_q, n_latched_d;
  logic [DW-1:0]          dly_cnt_q, dly_cnt_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [15:0]            num_errors_q, num_errors_d;
  logic                   err_pulse_q, err_pulse_d;
  logic [AW-1:0]          err_index_q, err_index_d;
  logic                   done_q, done_d;

  // Expected-message table; deliberately not reset.
  logic [p_msg_nbits-1:0] tbl_q [p_num_msgs];

  logic [DW-1:0]          d_now;
  logic [NW-1:0]          n_start;
  logic                   mismatch;
  logic                   last_idx;
  logic                   tbl_wen;

  // Galois LFSR x^16+x^14+x^13+x^11, right-shifting form.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ ({16{v[0]}} & 16'hB400);
  endfunction

  // Back-pressure length drawn from the current LFSR value.
  function automatic logic [DW-1:0] sample_delay(input logic [15:0] v);
    return DW'(32'(v) % 32'(p_max_delay + 1));
  endfunction

  // Error counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Requests larger than the table are limited to the table depth.
  function automatic logic [NW-1:0] clamp_n(input logic [NW-1:0] v);
    return (v > NW'(p_num_msgs)) ? NW'(p_num_msgs) : v;
  endfunction

  assign d_now    = sample_delay(lfsr_q);
  assign n_start  = clamp_n(cfg_num_msgs);
  // 4-state compare so an X/Z bit from the upstream device counts as an error.
  assign mismatch = (in_msg !== tbl_q[idx_q]);
  assign last_idx = ({1'b0, idx_q} == (n_latched_q - NW'(1)));
  assign tbl_wen  = cfg_wen && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Next-state and datapath decisions for the checking sequencer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    n_latched_d  = n_latched_q;
    dly_cnt_d    = dly_cnt_q;
    num_errors_d = num_errors_q;
    err_index_d  = err_index_q;
    err_pulse_d  = 1'b0;
    lfsr_d       = lfsr_next(lfsr_q);
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_latched_d  = n_start;
          idx_d        = '0;
          num_errors_d = '0;
          if (n_start == '0) begin
            state_d = S_DONE;
          end else if (d_now == '0) begin
            state_d = S_ACCEPT;
          end else begin
            dly_cnt_d = d_now;
            state_d   = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        dly_cnt_d = dly_cnt_q - DW'(1);
        if (dly_cnt_q == DW'(1)) state_d = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (in_val) begin
          if (mismatch) begin
            err_pulse_d  = 1'b1;
            err_index_d  = idx_q;
            num_errors_d = sat_inc(num_errors_q);
          end
          if (last_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + AW'(1);
            if (d_now == '0) begin
              state_d = S_ACCEPT;
            end else begin
              dly_cnt_d = d_now;
              state_d   = S_DELAY;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  // Control and status registers; everything returns to idle on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      n_latched_q  <= '0;
      dly_cnt_q    <= '0;
      lfsr_q       <= p_lfsr_seed;
      num_errors_q <= '0;
      err_pulse_q  <= 1'b0;
      err_index_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      n_latched_q  <= n_latched_d;
      dly_cnt_q    <= dly_cnt_d;
      lfsr_q       <= lfsr_d;
      num_errors_q <= num_errors_d;
      err_pulse_q  <= err_pulse_d;
      err_index_q  <= err_index_d;
      done_q       <= done_d;
    end
  end

  // Table writes are only accepted while no run is in progress.
  always_ff @(posedge clk) begin
    if (tbl_wen) tbl_q[cfg_waddr] <= cfg_wdata;
  end

  assign in_rdy     = (state_q == S_ACCEPT);
  assign done       = done_q;
  assign num_errors = num_errors_q;
  assign err_pulse  = err_pulse_q;
  assign err_index  = err_index_q;

endmodule

// File: tb/tb_vc_test_delay_sink.sv
// Bench for vc_test_delay_sink: two instances (no back-pressure and up to 7
// cycles of back-pressure) driven side by side and compared against a
// schedule-based reference model of the sink.
module tb_vc_test_delay_sink;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_wen = 1'b0;
  logic [5:0]  cfg_waddr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [6:0]  cfg_num_msgs = '0;
  logic        start_i  [2];
  logic        in_val_i [2];
  logic [31:0] in_msg_i [2];
  logic        in_rdy_o [2];
  logic        done_o   [2];
  logic [15:0] nerr_o   [2];
  logic        errp_o   [2];
  logic [5:0]  erri_o   [2];

  int errors = 0;
  int checks = 0;

  // Reference model state, one set per instance.
  logic [15:0] m_lfsr [2];
  bit          m_busy [2];
  int          m_wait [2];
  int          m_idx  [2];
  int          m_n    [2];
  int          m_errs [2];
  bit          m_done [2];
  bit          m_errp [2];
  int          m_erri [2];
  logic [31:0] m_tab  [2][64];

  always #5 clk = ~clk;

  vc_test_delay_sink #(.p_msg_nbits(32), .p_num_msgs(64), .p_max_delay(0), .p_lfsr_seed(16'hACE1)) u_d0 (
    .clk(clk), .reset(reset), .cfg_wen(cfg_wen), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
    .cfg_num_msgs(cfg_num_msgs), .start(start_i[0]), .in_val(in_val_i[0]), .in_rdy(in_rdy_o[0]),
    .in_msg(in_msg_i[0]), .done(done_o[0]), .num_errors(nerr_o[0]), .err_pulse(errp_o[0]),
    .err_index(erri_o[0]));

  vc_test_delay_sink #(.p_msg_nbits(32), .p_num_msgs(64), .p_max_delay(7), .p_lfsr_seed(16'hACE1)) u_d7 (
    .clk(clk), .reset(reset), .cfg_wen(cfg_wen), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
    .cfg_num_msgs(cfg_num_msgs), .start(start_i[1]), .in_val(in_val_i[1]), .in_rdy(in_rdy_o[1]),
    .in_msg(in_msg_i[1]), .done(done_o[1]), .num_errors(nerr_o[1]), .err_pulse(errp_o[1]),
    .err_index(erri_o[1]));

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int dmax(input int k);
    return (k == 0) ? 0 : 7;
  endfunction

  function automatic bit m_rdy(input int k);
    return m_busy[k] && (m_wait[k] == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lfsr[k] = 16'hACE1; m_busy[k] = 0; m_wait[k] = 0; m_idx[k] = 0; m_n[k] = 0;
      m_errs[k] = 0; m_done[k] = 0; m_errp[k] = 0; m_erri[k] = 0;
    end
  endtask

  // One clock edge of the model: a run is a countdown of wait cycles before
  // each message slot, with the wait length drawn from the LFSR value current
  // at the edge that opened the slot.
  task automatic model_step(input int k);
    int dly;
    int n;
    dly = int'(m_lfsr[k]) % (dmax(k) + 1);
    m_errp[k] = 0;
    if (!m_busy[k]) begin
      if (cfg_wen) m_tab[k][cfg_waddr] = cfg_wdata;
      if (start_i[k]) begin
        n = (int'(cfg_num_msgs) > 64) ? 64 : int'(cfg_num_msgs);
        m_n[k] = n; m_idx[k] = 0; m_errs[k] = 0;
        if (n == 0) m_done[k] = 1;
        else begin m_done[k] = 0; m_busy[k] = 1; m_wait[k] = dly; end
      end
    end else if (m_wait[k] > 0) begin
      m_wait[k]--;
    end else if (in_val_i[k]) begin
      if (in_msg_i[k] !== m_tab[k][m_idx[k]]) begin
        if (m_errs[k] < 65535) m_errs[k]++;
        m_errp[k] = 1;
        m_erri[k] = m_idx[k];
      end
      if (m_idx[k] == m_n[k] - 1) begin m_busy[k] = 0; m_done[k] = 1; end
      else begin m_idx[k]++; m_wait[k] = dly; end
    end
    m_lfsr[k] = lfsr_step(m_lfsr[k]);
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic load(input int a, input logic [31:0] v);
    cfg_wen = 1'b1; cfg_waddr = 6'(a); cfg_wdata = v;
    cyc();
    cfg_wen = 1'b0;
  endtask

  task automatic start_run(input int k, input int n);
    cfg_num_msgs = 7'(n); start_i[k] = 1'b1;
    cyc();
    start_i[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [31:0] v);
    in_val_i[k] = 1'b1; in_msg_i[k] = v;
    cyc();
    in_val_i[k] = 1'b0;
  endtask

  task automatic test_reset();
    assert_reset();
    for (int k = 0; k < 2; k++) begin
      checks++; if (in_rdy_o[k] !== 1'b0) begin errors++; $display("FAIL reset_rdy[%0d]: got %b want 0", k, in_rdy_o[k]); end
      checks++; if (done_o[k] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b want 0", k, done_o[k]); end
      checks++; if (nerr_o[k] !== 16'd0) begin errors++; $display("FAIL reset_nerr[%0d]: got %0d want 0", k, nerr_o[k]); end
      checks++; if (errp_o[k] !== 1'b0) begin errors++; $display("FAIL reset_errp[%0d]: got %b want 0", k, errp_o[k]); end
      checks++; if (erri_o[k] !== 6'd0) begin errors++; $display("FAIL reset_erri[%0d]: got %0d want 0", k, erri_o[k]); end
    end
    release_reset();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [3];
    v = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) load(i, v[i]);
    start_run(0, 3);
    checks++; if (in_rdy_o[0] !== 1'b1) begin errors++; $display("FAIL b2b_rdy_first: got %b want 1", in_rdy_o[0]); end
    in_val_i[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_msg_i[0] = v[j];
      cyc();
      checks++; if (errp_o[0] !== 1'b0) begin errors++; $display("FAIL b2b_errp%0d: got %b want 0", j, errp_o[0]); end
      checks++; if (in_rdy_o[0] !== (j < 2)) begin errors++; $display("FAIL b2b_rdy%0d: got %b want %b", j, in_rdy_o[0], j < 2); end
      checks++; if (done_o[0] !== (j == 2)) begin errors++; $display("FAIL b2b_done%0d: got %b want %b", j, done_o[0], j == 2); end
    end
    in_val_i[0] = 1'b0;
    checks++; if (nerr_o[0] !== 16'd0) begin errors++; $display("FAIL b2b_nerr: got %0d want 0", nerr_o[0]); end
  endtask

  task automatic test_mismatch();
    logic [31:0] w [3];
    int pulses;
    w = '{32'h11, 32'h99, 32'h33};
    pulses = 0;
    start_run(0, 3);
    in_val_i[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_msg_i[0] = w[j];
      cyc();
      if (errp_o[0] === 1'b1) pulses++;
      checks++; if (errp_o[0] !== (j == 1)) begin errors++; $display("FAIL mis_errp%0d: got %b want %b", j, errp_o[0], j == 1); end
    end
    in_val_i[0] = 1'b0;
    cyc();
    checks++; if (pulses != 1) begin errors++; $display("FAIL mis_pulses: got %0d want 1", pulses); end
    checks++; if (errp_o[0] !== 1'b0) begin errors++; $display("FAIL mis_errp_after: got %b want 0", errp_o[0]); end
    checks++; if (erri_o[0] !== 6'd1) begin errors++; $display("FAIL mis_erri: got %0d want 1", erri_o[0]); end
    checks++; if (nerr_o[0] !== 16'd1) begin errors++; $display("FAIL mis_nerr: got %0d want 1", nerr_o[0]); end
    checks++; if (done_o[0] !== 1'b1) begin errors++; $display("FAIL mis_done: got %b want 1", done_o[0]); end
  endtask

  task automatic test_zero_msgs();
    start_run(0, 0);
    checks++; if (done_o[0] !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done_o[0]); end
    checks++; if (nerr_o[0] !== 16'd0) begin errors++; $display("FAIL zero_nerr_start: got %0d want 0", nerr_o[0]); end
    in_val_i[0] = 1'b1; in_msg_i[0] = 32'hDEAD;
    for (int j = 0; j < 3; j++) begin
      cyc();
      checks++; if (in_rdy_o[0] !== 1'b0) begin errors++; $display("FAIL zero_rdy%0d: got %b want 0", j, in_rdy_o[0]); end
      checks++; if (nerr_o[0] !== 16'd0 || errp_o[0] !== 1'b0) begin errors++; $display("FAIL zero_err%0d: got %0d/%b want 0/0", j, nerr_o[0], errp_o[0]); end
    end
    in_val_i[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v [4];
    v = '{32'h1000, 32'h2001, 32'h3002, 32'h4003};
    for (int i = 0; i < 4; i++) load(i, v[i]);
    start_run(0, 4);
    send(0, v[0]);
    send(0, v[1] ^ 32'h8);
    checks++; if (nerr_o[0] !== 16'd1) begin errors++; $display("FAIL mid_nerr_pre: got %0d want 1", nerr_o[0]); end
    assert_reset();
    checks++; if (in_rdy_o[0] !== 1'b0) begin errors++; $display("FAIL mid_rdy: got %b want 0", in_rdy_o[0]); end
    checks++; if (done_o[0] !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", done_o[0]); end
    checks++; if (nerr_o[0] !== 16'd0) begin errors++; $display("FAIL mid_nerr: got %0d want 0", nerr_o[0]); end
    checks++; if (errp_o[0] !== 1'b0) begin errors++; $display("FAIL mid_errp: got %b want 0", errp_o[0]); end
    release_reset();
    checks++; if (in_rdy_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b/%b want 0/0", in_rdy_o[0], done_o[0]); end
    start_run(0, 4);
    for (int j = 0; j < 4; j++) begin
      checks++; if (in_rdy_o[0] !== 1'b1) begin errors++; $display("FAIL mid_rerun_rdy%0d: got %b want 1", j, in_rdy_o[0]); end
      send(0, v[j]);
    end
    checks++; if (nerr_o[0] !== 16'd0) begin errors++; $display("FAIL mid_rerun_nerr: got %0d want 0", nerr_o[0]); end
    checks++; if (done_o[0] !== 1'b1) begin errors++; $display("FAIL mid_rerun_done: got %b want 1", done_o[0]); end
  endtask

  task automatic test_x_and_cfg();
    logic [31:0] v [3];
    logic [31:0] t;
    v = '{32'hA1, 32'hB3, 32'hC5};
    for (int i = 0; i < 3; i++) load(i, v[i]);
    start_run(0, 3);
    send(0, v[0]);
    t = v[1];
    in_val_i[0] = 1'b1; in_msg_i[0] = {t[31:1], 1'bx};
    cfg_wen = 1'b1; cfg_waddr = 6'd1; cfg_wdata = 32'hFFFF0000;
    cyc();
    cfg_wen = 1'b0; in_val_i[0] = 1'b0;
    checks++; if (errp_o[0] !== 1'b1) begin errors++; $display("FAIL x_errp: got %b want 1", errp_o[0]); end
    checks++; if (erri_o[0] !== 6'd1) begin errors++; $display("FAIL x_erri: got %0d want 1", erri_o[0]); end
    send(0, v[2]);
    checks++; if (nerr_o[0] !== 16'd1) begin errors++; $display("FAIL x_nerr: got %0d want 1", nerr_o[0]); end
    checks++; if (done_o[0] !== 1'b1) begin errors++; $display("FAIL x_done: got %b want 1", done_o[0]); end
    start_run(0, 3);
    for (int j = 0; j < 3; j++) send(0, v[j]);
    checks++; if (nerr_o[0] !== 16'd0) begin errors++; $display("FAIL cfg_readback_nerr: got %0d want 0", nerr_o[0]); end
    checks++; if (done_o[0] !== 1'b1) begin errors++; $display("FAIL cfg_readback_done: got %b want 1", done_o[0]); end
  endtask

  task automatic test_random_delay();
    logic [31:0] vals [16];
    bit          bad  [16];
    int p, last, cycle, nbad, gap;
    bit pre;
    nbad = 0;
    for (int i = 0; i < 16; i++) begin
      vals[i] = $urandom;
      bad[i]  = ($urandom_range(0, 3) == 0);
      if (bad[i]) nbad++;
      load(i, vals[i]);
    end
    start_run(1, 16);
    p = 0; last = 0; cycle = 0;
    in_val_i[1] = 1'b1;
    while (p < 16 && cycle < 200) begin
      in_msg_i[1] = bad[p] ? (vals[p] ^ 32'h1) : vals[p];
      pre = in_rdy_o[1];
      cyc();
      cycle++;
      checks++; if (in_rdy_o[1] !== m_rdy(1)) begin errors++; $display("FAIL rnd_rdy@%0d: got %b want %b", cycle, in_rdy_o[1], m_rdy(1)); end
      checks++; if (errp_o[1] !== m_errp[1]) begin errors++; $display("FAIL rnd_errp@%0d: got %b want %b", cycle, errp_o[1], m_errp[1]); end
      if (pre) begin
        gap = cycle - last - 1;
        checks++; if (gap < 0 || gap > 7) begin errors++; $display("FAIL rnd_gap%0d: got %0d want 0..7", p, gap); end
        last = cycle;
        p++;
      end
    end
    in_val_i[1] = 1'b0;
    checks++; if (p != 16) begin errors++; $display("FAIL rnd_transfers: got %0d want 16", p); end
    checks++; if (done_o[1] !== 1'b1) begin errors++; $display("FAIL rnd_done: got %b want 1", done_o[1]); end
    checks++; if (nerr_o[1] !== 16'(nbad)) begin errors++; $display("FAIL rnd_nerr: got %0d want %0d", nerr_o[1], nbad); end
    checks++; if (int'(nerr_o[1]) != m_errs[1]) begin errors++; $display("FAIL rnd_nerr_model: got %0d want %0d", nerr_o[1], m_errs[1]); end
  endtask

  task automatic test_clamp();
    logic [31:0] vals [64];
    int p, cycle;
    bit pre;
    for (int i = 0; i < 64; i++) begin vals[i] = $urandom; load(i, vals[i]); end
    start_run(0, 127);
    p = 0; cycle = 0;
    in_val_i[0] = 1'b1;
    while (done_o[0] !== 1'b1 && cycle < 100) begin
      in_msg_i[0] = vals[p % 64];
      pre = in_rdy_o[0];
      cyc();
      cycle++;
      if (pre) p++;
    end
    in_val_i[0] = 1'b0;
    checks++; if (p != 64) begin errors++; $display("FAIL clamp_transfers: got %0d want 64", p); end
    checks++; if (done_o[0] !== 1'b1) begin errors++; $display("FAIL clamp_done: got %b want 1", done_o[0]); end
    checks++; if (nerr_o[0] !== 16'd0) begin errors++; $display("FAIL clamp_nerr: got %0d want 0", nerr_o[0]); end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      start_i[k] = 1'b0; in_val_i[k] = 1'b0; in_msg_i[k] = '0;
    end
    model_reset();
    #1;
    test_reset();
    test_back_to_back();
    test_mismatch();
    test_zero_msgs();
    test_reset_mid();
    test_x_and_cfg();
    test_random_delay();
    test_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
